// File: rtl/bottling_pkg.sv
// Shared encodings for the pill-bottling controller: FSM states, error codes,
// beeper request codes and the single-digit BCD increment used by the counters.
package bottling_pkg;

    typedef enum logic [2:0] {
        ST_SETTING   = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_SWITCHING = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4,
        ST_FATAL     = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_HOPPER   = 2'd1;
    localparam logic [1:0] ERR_CONVEYOR = 2'd2;
    localparam logic [1:0] ERR_ESTOP    = 2'd3;

    localparam logic [1:0] BEEP_OFF   = 2'd0;
    localparam logic [1:0] BEEP_DONE  = 2'd1;
    localparam logic [1:0] BEEP_ERROR = 2'd2;
    localparam logic [1:0] BEEP_FATAL = 2'd3;

    // One BCD digit plus one; 9 (or any non-BCD code) rolls over to 0.
    function automatic logic [3:0] digit_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bottling_ctrl_p_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear. Each digit carries into
// the next on 9 -> 0; an all-nines value wraps to zero.
module bcd_counter
    import bottling_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count
);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_d;
    logic [4*DIGITS-1:0] count_inc;
    logic                carry;

    // Ripple the +1 through the digits, stopping at the first digit that is not 9.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                count_inc[4*i +: 4] = digit_inc(count_q[4*i +: 4]);
                carry               = (count_q[4*i +: 4] == 4'd9);
            end
        end
    end

    // Clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_inc;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bottling_ctrl_p.sv
// Pill-bottling controller: button-entered BCD targets, pill and bottle
// counting, changeover and hopper-starvation timing, retry-limited resume.
module bottling_ctrl_p
    import bottling_pkg::*;
#(
    parameter int PILL_DIGITS       = 3,
    parameter int BOTTLE_DIGITS     = 2,
    parameter int SWITCH_MS         = 2000,
    parameter int HOPPER_TIMEOUT_MS = 3000,
    parameter int MAX_RETRIES       = 3,
    localparam int CW = (PILL_DIGITS + BOTTLE_DIGITS > 1) ? $clog2(PILL_DIGITS + BOTTLE_DIGITS) : 1
) (
    input  logic                       clk_1khz,
    input  logic                       switch_clr,
    input  logic                       btn_pos,
    input  logic                       btn_inc,
    input  logic                       btn_start,
    input  logic                       emergency_stop,
    input  logic                       hopper_pulse,
    input  logic                       conveyor_ok,
    output logic [2:0]                 state,
    output logic [CW-1:0]              cursor,
    output logic [4*PILL_DIGITS-1:0]   target_pills,
    output logic [4*BOTTLE_DIGITS-1:0] target_bottles,
    output logic [4*PILL_DIGITS-1:0]   now_pills,
    output logic [4*BOTTLE_DIGITS-1:0] now_bottles,
    output logic [1:0]                 err_code,
    output logic                       bottle_done,
    output logic [1:0]                 beep_req
);

    localparam int TMAX = (SWITCH_MS > HOPPER_TIMEOUT_MS) ? SWITCH_MS : HOPPER_TIMEOUT_MS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int ND   = PILL_DIGITS + BOTTLE_DIGITS;

    localparam logic [TW-1:0] SWITCH_LOAD = TW'(SWITCH_MS);
    localparam logic [TW-1:0] HOP_LOAD    = TW'(HOPPER_TIMEOUT_MS);
    localparam logic [TW-1:0] TMR_ONE     = TW'(1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
    localparam logic [CW-1:0] CURSOR_LAST = CW'(ND - 1);

    state_e                     state_q, state_d;
    logic [CW-1:0]              cursor_q, cursor_d;
    logic [4*PILL_DIGITS-1:0]   tp_q, tp_d;
    logic [4*BOTTLE_DIGITS-1:0] tb_q, tb_d;
    logic [TW-1:0]              hop_q, hop_d;
    logic [TW-1:0]              sw_q, sw_d;
    logic [RW-1:0]              retries_q, retries_d;
    logic [1:0]                 err_q, err_d;
    logic                       resume_sw_q, resume_sw_d;
    logic                       done_q, done_d;

    logic                       pill_clr, pill_inc, bot_clr, bot_inc;
    logic                       estop_hit;
    logic [4*BOTTLE_DIGITS-1:0] bottles_plus_one;
    logic                       bcarry;

    bcd_counter #(.DIGITS(PILL_DIGITS)) u_pills (
        .clk   (clk_1khz),
        .rst_n (switch_clr),
        .clr   (pill_clr),
        .inc   (pill_inc),
        .count (now_pills)
    );

    bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_bottles (
        .clk   (clk_1khz),
        .rst_n (switch_clr),
        .clr   (bot_clr),
        .inc   (bot_inc),
        .count (now_bottles)
    );

    // Bottle count as it will read after the bottle now finishing is counted.
    always_comb begin
        bottles_plus_one = now_bottles;
        bcarry           = 1'b1;
        for (int i = 0; i < BOTTLE_DIGITS; i++) begin
            if (bcarry) begin
                bottles_plus_one[4*i +: 4] = digit_inc(now_bottles[4*i +: 4]);
                bcarry                     = (now_bottles[4*i +: 4] == 4'd9);
            end
        end
    end

    // Emergency stop only acts once the line has been started; SETTING and FATAL ignore it.
    always_comb begin
        estop_hit = emergency_stop &&
                    (state_q == ST_RUNNING || state_q == ST_SWITCHING ||
                     state_q == ST_ERROR   || state_q == ST_DONE);
    end

    // Next-state logic: emergency stop first, then per-state events.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        tp_d        = tp_q;
        tb_d        = tb_q;
        hop_d       = hop_q;
        sw_d        = sw_q;
        retries_d   = retries_q;
        err_d       = err_q;
        resume_sw_d = resume_sw_q;
        done_d      = 1'b0;
        pill_clr    = 1'b0;
        pill_inc    = 1'b0;
        bot_clr     = 1'b0;
        bot_inc     = 1'b0;

        if (estop_hit) begin
            state_d = ST_FATAL;
            err_d   = ERR_ESTOP;
        end else begin
            case (state_q)
                ST_SETTING: begin
                    if (btn_inc) begin
                        for (int i = 0; i < PILL_DIGITS; i++) begin
                            if (cursor_q == CW'(i)) begin
                                tp_d[4*i +: 4] = digit_inc(tp_q[4*i +: 4]);
                            end
                        end
                        for (int i = 0; i < BOTTLE_DIGITS; i++) begin
                            if (cursor_q == CW'(PILL_DIGITS + i)) begin
                                tb_d[4*i +: 4] = digit_inc(tb_q[4*i +: 4]);
                            end
                        end
                    end
                    if (btn_pos) begin
                        cursor_d = (cursor_q == CURSOR_LAST) ? '0 : cursor_q + CW'(1);
                    end
                    if (btn_start && (tp_q != '0) && (tb_q != '0)) begin
                        state_d   = ST_RUNNING;
                        pill_clr  = 1'b1;
                        bot_clr   = 1'b1;
                        hop_d     = HOP_LOAD;
                        retries_d = '0;
                        err_d     = ERR_NONE;
                    end
                end
                ST_RUNNING: begin
                    if (now_pills == tp_q) begin
                        bot_inc = 1'b1;
                        done_d  = 1'b1;
                        sw_d    = SWITCH_LOAD;
                        state_d = (bottles_plus_one == tb_q) ? ST_DONE : ST_SWITCHING;
                    end else if (hopper_pulse) begin
                        pill_inc = 1'b1;
                        hop_d    = HOP_LOAD;
                    end else if (hop_q <= TMR_ONE) begin
                        hop_d       = '0;
                        state_d     = ST_ERROR;
                        err_d       = ERR_HOPPER;
                        resume_sw_d = 1'b0;
                    end else begin
                        hop_d = hop_q - TMR_ONE;
                    end
                end
                ST_SWITCHING: begin
                    if (sw_q <= TMR_ONE) begin
                        sw_d = '0;
                        if (conveyor_ok) begin
                            state_d  = ST_RUNNING;
                            pill_clr = 1'b1;
                            hop_d    = HOP_LOAD;
                        end else begin
                            state_d     = ST_ERROR;
                            err_d       = ERR_CONVEYOR;
                            resume_sw_d = 1'b1;
                        end
                    end else begin
                        sw_d = sw_q - TMR_ONE;
                    end
                end
                ST_ERROR: begin
                    if (btn_start) begin
                        if (retries_q == RETRY_MAX) begin
                            state_d = ST_FATAL;
                        end else begin
                            retries_d = retries_q + RW'(1);
                            err_d     = ERR_NONE;
                            if (resume_sw_q) begin
                                state_d = ST_SWITCHING;
                                sw_d    = SWITCH_LOAD;
                            end else begin
                                state_d = ST_RUNNING;
                                hop_d   = HOP_LOAD;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (btn_start) begin
                        state_d  = ST_SETTING;
                        pill_clr = 1'b1;
                        bot_clr  = 1'b1;
                    end
                end
                ST_FATAL: begin
                    state_d = ST_FATAL;
                end
                default: begin
                    state_d = ST_SETTING;
                end
            endcase
        end
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk_1khz) begin
        if (!switch_clr) begin
            state_q     <= ST_SETTING;
            cursor_q    <= '0;
            tp_q        <= '0;
            tb_q        <= '0;
            hop_q       <= '0;
            sw_q        <= '0;
            retries_q   <= '0;
            err_q       <= ERR_NONE;
            resume_sw_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            tp_q        <= tp_d;
            tb_q        <= tb_d;
            hop_q       <= hop_d;
            sw_q        <= sw_d;
            retries_q   <= retries_d;
            err_q       <= err_d;
            resume_sw_q <= resume_sw_d;
            done_q      <= done_d;
        end
    end

    // Beeper request is a pure decode of the current state.
    always_comb begin
        beep_req = BEEP_OFF;
        case (state_q)
            ST_DONE:  beep_req = BEEP_DONE;
            ST_ERROR: beep_req = BEEP_ERROR;
            ST_FATAL: beep_req = BEEP_FATAL;
            default:  beep_req = BEEP_OFF;
        endcase
    end

    assign state          = state_q;
    assign cursor         = cursor_q;
    assign target_pills   = tp_q;
    assign target_bottles = tb_q;
    assign err_code       = err_q;
    assign bottle_done    = done_q;

endmodule

// File: tb/tb_bottling_ctrl_p.sv
// Self-checking bench for bottling_ctrl_p: directed scenarios plus randomized
// traffic, all compared against an integer-level behavioural model.
module tb_bottling_ctrl_p;

    localparam int P  = 3;
    localparam int B  = 2;
    localparam int SW = 20;
    localparam int HT = 30;
    localparam int MR = 1;

    localparam int M_SET = 0, M_RUN = 1, M_SW = 2, M_DONE = 3, M_ERR = 4, M_FATAL = 5;

    logic        clk_1khz = 1'b0;
    logic        switch_clr, btn_pos, btn_inc, btn_start, emergency_stop, hopper_pulse, conveyor_ok;
    logic [2:0]  state;
    logic [2:0]  cursor;
    logic [11:0] target_pills;
    logic [7:0]  target_bottles;
    logic [11:0] now_pills;
    logic [7:0]  now_bottles;
    logic [1:0]  err_code;
    logic        bottle_done;
    logic [1:0]  beep_req;

    int checks = 0;
    int errors = 0;
    int donePulses = 0;

    int mState, mCursor, mPills, mBottles, mHop, mSw, mRetries, mErr, mResume, mDone;
    int mDig[5];

    bottling_ctrl_p #(
        .PILL_DIGITS(P), .BOTTLE_DIGITS(B), .SWITCH_MS(SW),
        .HOPPER_TIMEOUT_MS(HT), .MAX_RETRIES(MR)
    ) dut (
        .clk_1khz(clk_1khz), .switch_clr(switch_clr), .btn_pos(btn_pos), .btn_inc(btn_inc),
        .btn_start(btn_start), .emergency_stop(emergency_stop), .hopper_pulse(hopper_pulse),
        .conveyor_ok(conveyor_ok), .state(state), .cursor(cursor), .target_pills(target_pills),
        .target_bottles(target_bottles), .now_pills(now_pills), .now_bottles(now_bottles),
        .err_code(err_code), .bottle_done(bottle_done), .beep_req(beep_req)
    );

    always #5 clk_1khz = ~clk_1khz;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    function automatic logic [63:0] toBcd(input int v);
        logic [63:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int tpVal();
        return mDig[0] + 10 * mDig[1] + 100 * mDig[2];
    endfunction

    function automatic int tbVal();
        return mDig[3] + 10 * mDig[4];
    endfunction

    function automatic int beepOf(input int s);
        return (s == M_DONE) ? 1 : (s == M_ERR) ? 2 : (s == M_FATAL) ? 3 : 0;
    endfunction

    task automatic modelStep(input logic clr, pos, inc, start, estop, pulse, conv);
        int oldTp, oldTb;
        oldTp = tpVal();
        oldTb = tbVal();
        mDone = 0;
        if (!clr) begin
            mState = M_SET; mCursor = 0; mPills = 0; mBottles = 0; mHop = 0; mSw = 0;
            mRetries = 0; mErr = 0; mResume = M_RUN;
            for (int i = 0; i < 5; i++) mDig[i] = 0;
        end else if (estop && mState >= M_RUN && mState <= M_ERR) begin
            mState = M_FATAL;
            mErr   = 3;
        end else begin
            case (mState)
                M_SET: begin
                    if (inc) mDig[mCursor] = (mDig[mCursor] + 1) % 10;
                    if (pos) mCursor = (mCursor + 1) % (P + B);
                    if (start && oldTp != 0 && oldTb != 0) begin
                        mState = M_RUN; mPills = 0; mBottles = 0; mHop = HT; mRetries = 0; mErr = 0;
                    end
                end
                M_RUN: begin
                    if (mPills == oldTp) begin
                        mBottles = (mBottles + 1) % 100;
                        mDone    = 1;
                        mSw      = SW;
                        mState   = (mBottles == oldTb) ? M_DONE : M_SW;
                    end else if (pulse) begin
                        mPills = (mPills + 1) % 1000;
                        mHop   = HT;
                    end else begin
                        mHop = mHop - 1;
                        if (mHop <= 0) begin
                            mHop = 0; mState = M_ERR; mErr = 1; mResume = M_RUN;
                        end
                    end
                end
                M_SW: begin
                    mSw = mSw - 1;
                    if (mSw <= 0) begin
                        mSw = 0;
                        if (conv) begin
                            mState = M_RUN; mPills = 0; mHop = HT;
                        end else begin
                            mState = M_ERR; mErr = 2; mResume = M_SW;
                        end
                    end
                end
                M_ERR: begin
                    if (start) begin
                        if (mRetries == MR) begin
                            mState = M_FATAL;
                        end else begin
                            mRetries++;
                            mErr   = 0;
                            mState = mResume;
                            if (mResume == M_SW) mSw = SW;
                            else                 mHop = HT;
                        end
                    end
                end
                M_DONE: begin
                    if (start) begin
                        mState = M_SET; mPills = 0; mBottles = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compareAll();
        checkOutput("state",          64'(state),          64'(mState));
        checkOutput("cursor",         64'(cursor),         64'(mCursor));
        checkOutput("target_pills",   64'(target_pills),   toBcd(tpVal()));
        checkOutput("target_bottles", 64'(target_bottles), toBcd(tbVal()));
        checkOutput("now_pills",      64'(now_pills),      toBcd(mPills));
        checkOutput("now_bottles",    64'(now_bottles),    toBcd(mBottles));
        checkOutput("err_code",       64'(err_code),       64'(mErr));
        checkOutput("bottle_done",    64'(bottle_done),    64'(mDone));
        checkOutput("beep_req",       64'(beep_req),       64'(beepOf(mState)));
    endtask

    task automatic applyStimulus(input logic clr, pos, inc, start, estop, pulse, conv);
        switch_clr     = clr;
        btn_pos        = pos;
        btn_inc        = inc;
        btn_start      = start;
        emergency_stop = estop;
        hopper_pulse   = pulse;
        conveyor_ok    = conv;
        modelStep(clr, pos, inc, start, estop, pulse, conv);
        @(posedge clk_1khz);
        #1;
        if (bottle_done === 1'b1) donePulses++;
        compareAll();
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic conv);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, conv);
    endtask

    task automatic pill();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic pressStart(input logic conv);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, conv);
    endtask

    task automatic pressPos();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pressInc();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Enters targets from the post-reset state (all digits 0, cursor 0).
    task automatic setTargets(input int pills, input int bottles);
        int d[5];
        d[0] = pills % 10; d[1] = (pills / 10) % 10; d[2] = (pills / 100) % 10;
        d[3] = bottles % 10; d[4] = (bottles / 10) % 10;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < d[i]; k++) pressInc();
            pressPos();
        end
    endtask

    initial begin
        int pulsePct, convPct;

        // Scenario 1: two bottles of three pills
        doReset();
        checkOutput("reset_state", 64'(state), 64'd0);
        setTargets(3, 2);
        pressStart(1'b1);
        donePulses = 0;
        repeat (3) pill();
        idle(1, 1'b1);
        idle(SW, 1'b1);
        repeat (3) pill();
        idle(1, 1'b1);
        checkOutput("t1_done_pulses", 64'(donePulses), 64'd2);
        checkOutput("t1_bottles", 64'(now_bottles), 64'h02);
        checkOutput("t1_state_done", 64'(state), 64'd3);
        checkOutput("t1_beep_done", 64'(beep_req), 64'd1);

        // Scenario 2: cursor wrap, digit wrap, start refused with zero bottles
        doReset();
        repeat (9) pressInc();
        pressPos();
        repeat (5) pressInc();
        repeat (3) pressPos();
        checkOutput("t2_cursor4", 64'(cursor), 64'd4);
        pressPos();
        checkOutput("t2_cursor_wrap", 64'(cursor), 64'd0);
        pressInc();
        checkOutput("t2_digit_wrap", 64'(target_pills), 64'h050);
        pressStart(1'b1);
        checkOutput("t2_no_start", 64'(state), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_pos_inc_digit", 64'(target_pills), 64'h051);
        checkOutput("t2_pos_inc_cursor", 64'(cursor), 64'd1);

        // Scenario 3: hopper starvation, one retry, then fatal
        doReset();
        setTargets(5, 1);
        pressStart(1'b1);
        pill();
        idle(HT, 1'b1);
        checkOutput("t3_err_state", 64'(state), 64'd4);
        checkOutput("t3_err_code", 64'(err_code), 64'd1);
        checkOutput("t3_pills_kept", 64'(now_pills), 64'h001);
        pressStart(1'b1);
        checkOutput("t3_resume", 64'(state), 64'd1);
        idle(HT, 1'b1);
        pressStart(1'b1);
        checkOutput("t3_fatal", 64'(state), 64'd5);
        checkOutput("t3_fatal_beep", 64'(beep_req), 64'd3);

        // Scenario 4: conveyor stopped at changeover, resume into SWITCHING
        doReset();
        setTargets(2, 3);
        pressStart(1'b1);
        repeat (2) pill();
        idle(1, 1'b1);
        idle(SW, 1'b0);
        checkOutput("t4_err_code", 64'(err_code), 64'd2);
        pressStart(1'b1);
        checkOutput("t4_resume_sw", 64'(state), 64'd2);
        idle(SW - 1, 1'b1);
        checkOutput("t4_still_sw", 64'(state), 64'd2);
        idle(1, 1'b1);
        checkOutput("t4_running", 64'(state), 64'd1);
        checkOutput("t4_pills_clr", 64'(now_pills), 64'h000);

        // Scenario 5: pulse beats expiry; pulse in completion cycle dropped
        doReset();
        setTargets(2, 2);
        pressStart(1'b1);
        idle(HT - 1, 1'b1);
        pill();
        checkOutput("t5_pulse_wins", 64'(state), 64'd1);
        checkOutput("t5_count", 64'(now_pills), 64'h001);
        pill();
        pill();
        checkOutput("t5_dropped", 64'(now_pills), 64'h002);
        checkOutput("t5_bottle", 64'(now_bottles), 64'h01);

        // Scenario 6: emergency stop, then reset clears everything
        doReset();
        setTargets(9, 1);
        pressStart(1'b1);
        repeat (2) pill();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_estop", 64'(state), 64'd5);
        checkOutput("t6_estop_code", 64'(err_code), 64'd3);
        pressStart(1'b1);
        checkOutput("t6_start_ignored", 64'(state), 64'd5);
        doReset();
        checkOutput("t6_reset_zero",
                    64'({state, cursor, target_pills, target_bottles, now_pills, now_bottles,
                         err_code, bottle_done, beep_req}), 64'd0);

        // Randomized traffic against the model
        for (int ep = 0; ep < 6; ep++) begin
            doReset();
            setTargets($urandom_range(1, 4), $urandom_range(1, 3));
            pulsePct = $urandom_range(3, 60);
            convPct  = $urandom_range(70, 100);
            for (int c = 0; c < 300; c++) begin
                applyStimulus(($urandom_range(0, 999) >= 3),
                              ($urandom_range(0, 99) < 5),
                              ($urandom_range(0, 99) < 5),
                              ($urandom_range(0, 99) < 4),
                              ($urandom_range(0, 999) < 5),
                              ($urandom_range(0, 99) < pulsePct),
                              ($urandom_range(0, 99) < convPct));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
